// File: rtl/fdiv16_seq.sv
// Iterative restoring divider for the 16-bit FP format shared with fmul16.
// One quotient bit per cycle; start-to-done latency is fixed at 14 cycles.
module fdiv16_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   Result,
  output logic [3:0]             ALUFlags
);

  localparam int QW = MAN_W + 2;
  localparam int CW = $clog2(QW + 1);
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
  } op_t;

  state_t              state, state_nx;
  op_t                 op;
  logic [CW-1:0]       cnt;
  logic [QW-1:0]       rem, dvs, q;
  logic [EXP_W+MAN_W:0] res_q, res_n;
  logic [3:0]          flg_q, flg_n;

  logic signed [EW-1:0] e0, e1;
  logic [MAN_W-1:0]     frac;
  logic                 azero, bzero, ovf, unf;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // DIV holds one extra cycle after the last quotient bit (cnt==QW);
  // that cycle is what makes the start-to-done latency 14 edges.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = DIV;
      DIV:  if (cnt == CW'(QW)) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: operand latch, restoring iteration, result commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op    <= '0;
      cnt   <= '0;
      rem   <= '0;
      dvs   <= '0;
      q     <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op.sign <= A[EXP_W+MAN_W] ^ B[EXP_W+MAN_W];
          op.ea   <= A[EXP_W+MAN_W-1:MAN_W];
          op.eb   <= B[EXP_W+MAN_W-1:MAN_W];
          rem     <= {2'b01, A[MAN_W-1:0]};
          dvs     <= {2'b01, B[MAN_W-1:0]};
          q       <= '0;
          cnt     <= '0;
        end
        DIV: if (cnt != CW'(QW)) begin
          // rem < 2*dvs always holds, so the shift never drops a set bit
          if (rem >= dvs) begin
            rem <= (rem - dvs) << 1;
            q   <= {q[QW-2:0], 1'b1};
          end else begin
            rem <= rem << 1;
            q   <= {q[QW-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
        end
        NORM: begin
          res_q <= res_n;
          flg_q <= flg_n;
        end
        default: ;
      endcase
    end
  end

  // Normalisation and special cases (truncating, no rounding)
  always_comb begin
    azero = (op.ea == '0);
    bzero = (op.eb == '0);
    e0    = $signed({2'b00, op.ea}) - $signed({2'b00, op.eb}) + $signed(EW'(BIAS));
    if (q[QW-1]) begin
      frac = q[QW-2:1];
      e1   = e0;
    end else begin
      frac = q[MAN_W-1:0];
      e1   = e0 - $signed(EW'(1));
    end
    ovf = !e1[EW-1] && (e1 >= $signed({2'b00, EMAX}));
    unf = e1[EW-1] || (e1 == $signed(EW'(0)));

    res_n = {op.sign, e1[EXP_W-1:0], frac};
    flg_n = '0;
    if (bzero) begin
      res_n    = {op.sign, EMAX, {MAN_W{1'b0}}};
      flg_n[1] = 1'b1;
    end else if (azero) begin
      res_n = {op.sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (ovf) begin
      res_n    = {op.sign, EMAX, {MAN_W{1'b0}}};
      flg_n[0] = 1'b1;
    end else if (unf) begin
      res_n    = {op.sign, {(EXP_W+MAN_W){1'b0}}};
      flg_n[0] = 1'b1;
    end
    flg_n[3] = res_n[EXP_W+MAN_W];
    flg_n[2] = (res_n[EXP_W+MAN_W-1:0] == '0);
  end

  assign Result   = res_q;
  assign ALUFlags = flg_q;

endmodule

// File: tb/tb_fdiv16_seq.sv
// Self-checking bench for fdiv16_seq: directed corner cases plus random
// operands against an arithmetic reference model.
module tb_fdiv16_seq;

  logic        clk, reset, start;
  logic [15:0] A, B;
  logic        busy, done;
  logic [15:0] Result;
  logic [3:0]  ALUFlags;

  int tests = 0;
  int fails = 0;

  fdiv16_seq #(.EXP_W(5), .MAN_W(10), .BIAS(15)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Result(Result), .ALUFlags(ALUFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: quotient of the significands scaled by 2^11, then the format rules.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, qv, e, fr;
    logic s, c, v;
    logic [15:0] r;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    s  = a[15] ^ b[15];
    c  = 1'b0;
    v  = 1'b0;
    if (eb == 0) begin
      r = {s, 15'h7C00};
      c = 1'b1;
    end else if (ea == 0) begin
      r = {s, 15'h0};
    end else begin
      ma = 1024 + int'(a[9:0]);
      mb = 1024 + int'(b[9:0]);
      qv = (ma * 2048) / mb;
      e  = ea - eb + 15;
      if (qv >= 2048) fr = (qv / 2) % 1024;
      else begin
        fr = qv % 1024;
        e  = e - 1;
      end
      if (e >= 31) begin
        r = {s, 15'h7C00};
        v = 1'b1;
      end else if (e <= 0) begin
        r = {s, 15'h0};
        v = 1'b1;
      end else begin
        r = {s, 5'(e), 10'(fr)};
      end
    end
    return {r[15], (r[14:0] == 15'h0), c, v, r};
  endfunction

  // One operation; inj=1 pulses a second start during DIV (must be ignored).
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input bit inj);
    logic [19:0] exp;
    int dc, nd, nb;
    logic [15:0] rcap;
    logic [3:0]  fcap;
    exp  = model(a, b);
    dc   = 0;
    nd   = 0;
    nb   = 0;
    rcap = '0;
    fcap = '0;
    chk({tag, "_idle"}, busy, 1'b0);
    @(negedge clk);
    start = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (inj && c == 3) start = 1'b1;
      if (inj && c == 4) start = 1'b0;
      if (busy) nb++;
      if (done) begin
        nd++;
        if (dc == 0) begin
          dc   = c;
          rcap = Result;
          fcap = ALUFlags;
        end
      end
    end
    chk({tag, "_lat"}, dc, 14);
    chk({tag, "_dwidth"}, nd, 1);
    chk({tag, "_busy"}, nb, 14);
    chk({tag, "_res"}, rcap, exp[15:0]);
    chk({tag, "_flg"}, fcap, exp[19:16]);
    chk({tag, "_hold"}, Result, exp[15:0]);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int nd;
    reset = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_res", Result, 16'h0);
    chk("rst_flg", ALUFlags, 4'h0);
    @(negedge clk);
    reset = 1'b1;

    do_op("six_two", 16'h4600, 16'h4000, 1'b0);
    chk("six_two_lit", Result, 16'h4200);
    do_op("one_three", 16'h3C00, 16'h4200, 1'b0);
    chk("one_three_lit", Result, 16'h3555);
    do_op("neg", 16'hC780, 16'h4100, 1'b0);
    chk("neg_lit", {ALUFlags, Result}, 20'h8C200);
    do_op("dz", 16'h3C00, 16'h0000, 1'b0);
    chk("dz_lit", {ALUFlags, Result}, 20'h27C00);
    do_op("zz", 16'h0000, 16'h0000, 1'b0);
    chk("zz_lit", {ALUFlags, Result}, 20'h27C00);
    do_op("azero", 16'h8000, 16'h4000, 1'b0);
    do_op("ovf", 16'h7BFF, 16'h0400, 1'b0);
    chk("ovf_lit", {ALUFlags, Result}, 20'h17C00);
    do_op("unf", 16'h0400, 16'h7800, 1'b0);
    chk("unf_lit", {ALUFlags, Result}, 20'h50000);
    do_op("inj", 16'h4600, 16'h3C00, 1'b1);
    chk("inj_lit", Result, 16'h4600);

    // Reset during DIV cycle 5: outputs clear immediately, no done follows
    @(negedge clk);
    start = 1'b1;
    A = 16'h4600;
    B = 16'h4000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_res", Result, 16'h0);
    chk("mid_flg", ALUFlags, 4'h0);
    nd = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("mid_nodone", nd, 0);
    do_op("post_rst", 16'hC780, 16'h4100, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 10 == 3) ra[14:10] = 5'd0;
      if (i % 10 == 7) rb[14:10] = 5'd0;
      if (i % 10 == 5) rb[14:10] = 5'd31;
      do_op("rnd", ra, rb, (i % 4) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
